if_fetch: RTL and testbench

Instruction-fetch stage of the 12-bit-PC RISC-V core. It owns the program counter, issues reads to the synchronous instruction ROM, and buffers the returned instruction/PC pairs in a small FIFO. It feeds the decode stage, which reads `pc_i`/`inst_i`, and it absorbs decode's load-use `stall_req` without losing fetched words. Taken branches and jumps from execute redirect it, which discards all wrong-path fetches.

---
 rtl/core_pkg.sv | 34 +++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/if_fetch.sv | 88 ++++++++
 tb/tb_if_fetch.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: widths, reset PC, NOP encoding and base opcodes.
// Imported by the fetch stage, its buffer, and the decode stage.
package core_pkg;

    localparam int PC_W   = 12;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [PC_W-1:0]   RESET_PC = 12'h000;

    // RV32I major opcodes (inst[6:0]) shared with decode
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Fetch -> decode bundle
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } if_id_t;

    // Word-align a byte address (drop the two low bits)
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO of {pc, inst} pairs with flush.
// Ports: push/push_pc/push_inst in, pop, flush; count and head (NOP/0 when empty) out.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int P_W   = PC_W,
    parameter int I_W   = INST_W,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [P_W-1:0]   push_pc,
    input  logic [I_W-1:0]   push_inst,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output logic [P_W-1:0]   head_pc,
    output logic [I_W-1:0]   head_inst
);

    logic [P_W-1:0] pc_mem   [DEPTH];
    logic [I_W-1:0] inst_mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    assign do_push    = push && !flush;

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Payload storage needs no reset: empty entries are masked at the head
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    assign head_pc   = head_valid ? pc_mem[rd_ptr] : '0;
    assign head_inst = head_valid ? inst_mem[rd_ptr] : I_W'(NOP_INST);

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, reads the sync ROM, buffers {pc, inst} for decode.
// Ports: clk, rst; imem_ce_o/addr_o/data_i; stall_i, redirect_i/pc_i; valid_o, pc_o, inst_o.
module if_fetch
    import core_pkg::*;
#(
    parameter int              PC_W     = core_pkg::PC_W,
    parameter int              INST_W   = core_pkg::INST_W,
    parameter logic [PC_W-1:0] RESET_PC = core_pkg::RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_ce_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic [INST_W-1:0] imem_data_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic              valid_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  inflight_pc;
    logic             inflight;
    logic             kill;
    logic [CNT_W-1:0] count;
    logic [OCC_W-1:0] occ;
    logic [PC_W-1:0]  redirect_tgt;
    logic             pop;
    logic             push;
    logic             issue;

    assign redirect_tgt = redirect_pc_i & ~PC_W'(3);

    assign pop  = valid_o && !stall_i && !redirect_i;
    assign push = inflight && !kill;

    // Credit: buffered + in-flight after this cycle's pop must fit,
    // so a response never arrives at a full buffer.
    assign occ   = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    assign issue = !rst && !redirect_i && (occ < OCC_W'(DEPTH));

    assign imem_ce_o   = issue;
    assign imem_addr_o = fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            inflight    <= 1'b0;
            kill        <= 1'b0;
        end else begin
            inflight <= issue;
            kill     <= redirect_i ? inflight : 1'b0;
            if (issue)
                inflight_pc <= fetch_pc;
            if (redirect_i)
                fetch_pc <= redirect_tgt;
            else if (issue)
                fetch_pc <= fetch_pc + PC_W'(4);
        end
    end

    // Redirect doubles as flush; the flush also drops a same-cycle response
    fetch_fifo #(
        .P_W   (PC_W),
        .I_W   (INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_pc    (inflight_pc),
        .push_inst  (imem_data_i),
        .pop        (pop),
        .flush      (redirect_i),
        .count      (count),
        .head_valid (valid_o),
        .head_pc    (pc_o),
        .head_inst  (inst_o)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch with a queue-based fetch stream model.
// Drives inputs at negedge, checks #1 later, advances the model per cycle.
module tb_if_fetch;
    import core_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ce_o;
    logic [11:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        stall_i;
    logic        redirect_i;
    logic [11:0] redirect_pc_i;
    logic        valid_o;
    logic [11:0] pc_o;
    logic [31:0] inst_o;

    int total = 0;
    int bad   = 0;

    // model state
    logic [11:0] mq[$];
    logic [11:0] m_fpc;
    logic [11:0] m_ppc;
    bit          m_pend;
    bit          m_kill;

    always #5 clk = ~clk;

    if_fetch #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_ce_o     (imem_ce_o),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .inst_o        (inst_o)
    );

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return {8'hA5, a ^ 12'h5A5, a};
    endfunction

    always @(posedge clk)
        if (imem_ce_o)
            imem_data_i <= rom_word(imem_addr_o);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc  = 12'h000;
        m_ppc  = 12'h000;
        m_pend = 0;
        m_kill = 0;
    endtask

    task automatic step(input bit s, input bit r, input logic [11:0] tgt,
                        input bit rs);
        bit pop;
        bit exp_ce;
        int occ;
        @(negedge clk);
        stall_i       = s;
        redirect_i    = r;
        redirect_pc_i = tgt;
        rst           = rs;
        #1;
        if (rs) begin
            chk("rst_valid", 32'(valid_o), 32'd0);
            chk("rst_pc", 32'(pc_o), 32'd0);
            chk("rst_inst", inst_o, NOP_INST);
            chk("rst_ce", 32'(imem_ce_o), 32'd0);
            chk("rst_addr", 32'(imem_addr_o), 32'h000);
            model_reset();
        end else begin
            chk("valid", 32'(valid_o), 32'(mq.size() > 0));
            chk("pc", 32'(pc_o), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            chk("inst", inst_o, (mq.size() > 0) ? rom_word(mq[0]) : NOP_INST);
            pop    = (mq.size() > 0) && !s && !r;
            occ    = mq.size() + int'(m_pend) - int'(pop);
            exp_ce = !r && (occ < DEPTH);
            chk("ce", 32'(imem_ce_o), 32'(exp_ce));
            if (exp_ce)
                chk("addr", 32'(imem_addr_o), 32'(m_fpc));
            if (r) begin
                mq.delete();
                m_kill = m_pend;
                m_pend = 0;
                m_fpc  = tgt & 12'hFFC;
            end else begin
                if (pop)
                    void'(mq.pop_front());
                if (m_pend && !m_kill)
                    mq.push_back(m_ppc);
                m_kill = 0;
                m_pend = exp_ce;
                if (exp_ce) begin
                    m_ppc = m_fpc;
                    m_fpc = m_fpc + 12'd4;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 12'h000, 0);
    endtask

    initial begin
        stall_i       = 0;
        redirect_i    = 0;
        redirect_pc_i = '0;
        rst           = 1;
        model_reset();
        for (int i = 0; i < 3; i++)
            step(0, 0, 12'h000, 1);
        run(6);
        // stall 5 cycles around pc 0x010
        for (int i = 0; i < 5; i++)
            step(1, 0, 12'h000, 0);
        run(6);
        // fill buffer, then redirect with a fetch in flight
        step(1, 0, 12'h000, 0);
        step(0, 1, 12'h100, 0);
        run(6);
        // redirect during stall, unaligned target
        step(1, 0, 12'h000, 0);
        step(1, 1, 12'h203, 0);
        step(1, 0, 12'h000, 0);
        run(5);
        // sequential wrap
        step(0, 1, 12'hFF8, 0);
        run(8);
        // reset mid-operation
        step(1, 0, 12'h000, 0);
        step(1, 0, 12'h000, 1);
        step(0, 0, 12'h000, 1);
        run(6);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) == 0, ($urandom % 10) == 0,
                 12'($urandom), ($urandom % 80) == 0);
        end
        run(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
